// File: rtl/regu_wb_arbiter_pkg.sv
// regu_wb_arbiter_pkg: shared widths, defaults and write-port select encoding for the writeback arbiter
package regu_wb_arbiter_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_STARVE_MAX = 4;
  localparam logic RST_ENABLE = 1'b0;
  typedef enum logic [1:0] {SEL_IDLE, SEL_EX, SEL_LU} wb_sel_e;
endpackage

// File: rtl/regu_wb_arbiter_scoreboard.sv
// regu_wb_arbiter_scoreboard: per-register busy bits for outstanding LU results
//   set_i/set_addr_i mark a register busy, clr_i/clr_addr_i release it (set wins on the same address),
//   q_addr_i/q_busy_o are three lookups that already ignore a same-cycle clear, busy_o is the raw vector.
module regu_wb_arbiter_scoreboard import regu_wb_arbiter_pkg::*; #(
  parameter int AW = DEF_REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic                 clr_i,
  input  logic [AW-1:0]        clr_addr_i,
  input  logic [2:0][AW-1:0]   q_addr_i,
  output logic [2:0]           q_busy_o,
  output logic [(1<<AW)-1:0]   busy_o
);
  localparam int NR = 1 << AW;
  logic [NR-1:0] busy, set_vec, clr_vec, busy_eff;
  assign set_vec = {{(NR-1){1'b0}}, set_i} << set_addr_i;
  assign clr_vec = {{(NR-1){1'b0}}, clr_i} << clr_addr_i;
  assign busy_eff = busy & ~clr_vec;
  assign busy_o = busy;
  // bit 0 is masked so x0 can never become busy
  always_ff @(posedge clk or negedge rst_n)
    if (rst_n == RST_ENABLE) busy <= '0;
    else busy <= (set_vec | (busy & ~clr_vec)) & {{(NR-1){1'b1}}, 1'b0};
  for (genvar g = 0; g < 3; g++) begin : g_q
    assign q_busy_o[g] = busy_eff[q_addr_i[g]];
  end
endmodule

// File: rtl/regu_wb_arbiter.sv
// regu_wb_arbiter: arbitrates the single regfile write port between EX and the long-latency unit
//   ex_*      : EX writeback, fixed priority, never back-pressured
//   lu_issue_*: LU instruction issued by ID, marks rd busy
//   lu_wb_*   : LU result handshake (valid held until lu_wb_ready_o)
//   id_*      : ID operands checked against busy registers, id_stall_o holds ID/IF
//   regu_rd_* : combinational regfile write port
module regu_wb_arbiter import regu_wb_arbiter_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_wr_en_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic [XLEN-1:0]   ex_rd_data_i,
  input  logic              lu_issue_i,
  input  logic [REG_AW-1:0] lu_issue_rd_i,
  input  logic              lu_wb_valid_i,
  input  logic [REG_AW-1:0] lu_wb_rd_i,
  input  logic [XLEN-1:0]   lu_wb_data_i,
  output logic              lu_wb_ready_o,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_rd_used_i,
  output logic              id_stall_o,
  output logic              regu_rd_wr_en_o,
  output logic [REG_AW-1:0] regu_rd_addr_o,
  output logic [XLEN-1:0]   regu_rd_data_o
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  wb_sel_e sel;
  logic act, lu_xfer, starve_block;
  logic [CW-1:0] starve_cnt;
  logic [2:0] hz;
  logic [(1<<REG_AW)-1:0] busy;
  // outputs are forced to zero for the whole time reset is held, not just at the edge
  assign act = rst_n != RST_ENABLE;
  assign sel = ex_wr_en_i ? SEL_EX : lu_wb_valid_i ? SEL_LU : SEL_IDLE;
  assign lu_xfer = act & lu_wb_valid_i & ~ex_wr_en_i;
  assign lu_wb_ready_o = lu_xfer;
  assign regu_rd_addr_o = !act ? '0 : sel == SEL_EX ? ex_rd_addr_i : sel == SEL_LU ? lu_wb_rd_i : '0;
  assign regu_rd_data_o = !act ? '0 : sel == SEL_EX ? ex_rd_data_i : sel == SEL_LU ? lu_wb_data_i : '0;
  assign regu_rd_wr_en_o = act & (sel != SEL_IDLE) & (regu_rd_addr_o != '0);
  regu_wb_arbiter_scoreboard #(.AW(REG_AW)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .set_i(lu_issue_i),
    .set_addr_i(lu_issue_rd_i),
    .clr_i(lu_xfer),
    .clr_addr_i(lu_wb_rd_i),
    .q_addr_i({id_rd_addr_i, id_rs2_addr_i, id_rs1_addr_i}),
    .q_busy_o(hz),
    .busy_o(busy)
  );
  // counts consecutive cycles the LU is denied; once saturated, ID is held so EX drains
  always_ff @(posedge clk or negedge rst_n)
    if (rst_n == RST_ENABLE) starve_cnt <= '0;
    else if (!lu_wb_valid_i || lu_xfer) starve_cnt <= '0;
    else if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
  assign starve_block = starve_cnt == CW'(STARVE_MAX);
  assign id_stall_o = act & (hz[0] | hz[1] | (id_rd_used_i & hz[2]) | starve_block);
  a_ex_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_wr_en_i && ex_rd_addr_i != '0 && busy[ex_rd_addr_i]));
  a_lu_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(lu_wb_valid_i && lu_wb_rd_i != '0 && !busy[lu_wb_rd_i]));
  a_lu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lu_wb_valid_i && !lu_wb_ready_o) |=> (lu_wb_valid_i && $stable(lu_wb_rd_i) && $stable(lu_wb_data_i)));
endmodule

// File: tb/tb_regu_wb_arbiter.sv
// tb_regu_wb_arbiter: randomized and directed scoreboard bench for regu_wb_arbiter
module tb_regu_wb_arbiter;
  localparam int SM = 4;
  logic clk = 0, rst_n = 0;
  logic ex_wr_en_i = 0, lu_issue_i = 0, lu_wb_valid_i = 0, id_rd_used_i = 0;
  logic [4:0] ex_rd_addr_i = '0, lu_issue_rd_i = '0, lu_wb_rd_i = '0;
  logic [4:0] id_rs1_addr_i = '0, id_rs2_addr_i = '0, id_rd_addr_i = '0;
  logic [31:0] ex_rd_data_i = '0, lu_wb_data_i = '0;
  logic lu_wb_ready_o, id_stall_o, regu_rd_wr_en_o;
  logic [4:0] regu_rd_addr_o;
  logic [31:0] regu_rd_data_o;
  always #5 clk = ~clk;
  regu_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ex_wr_en_i(ex_wr_en_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i),
    .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
    .lu_wb_valid_i(lu_wb_valid_i), .lu_wb_rd_i(lu_wb_rd_i), .lu_wb_data_i(lu_wb_data_i),
    .lu_wb_ready_o(lu_wb_ready_o),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rd_used_i(id_rd_used_i), .id_stall_o(id_stall_o),
    .regu_rd_wr_en_o(regu_rd_wr_en_o), .regu_rd_addr_o(regu_rd_addr_o), .regu_rd_data_o(regu_rd_data_o)
  );
  typedef struct { bit rdy; bit stl; bit wen; } cyc_t;
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  cyc_t cycq[$];
  wr_t wq[$];
  int checks = 0, errors = 0;
  bit pend[32];
  int denied = 0;
  logic [4:0] luq[$];
  bit lu_v = 0, auto_lu = 0;
  logic [4:0] lu_rd = '0;
  logic [31:0] lu_d = '0;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic bit eff(input logic [4:0] r, input bit xfer);
    return r != 0 && pend[r] && !(xfer && lu_rd == r);
  endfunction
  cyc_t mc;
  wr_t mw;
  always @(negedge clk)
    if (rst_n && cycq.size() > 0) begin
      mc = cycq.pop_front();
      chk("lu_wb_ready", lu_wb_ready_o, mc.rdy);
      chk("id_stall", id_stall_o, mc.stl);
      chk("wr_en", regu_rd_wr_en_o, mc.wen);
      if (mc.wen && wq.size() > 0) begin
        mw = wq.pop_front();
        if (regu_rd_wr_en_o) begin
          chk("wr_addr", regu_rd_addr_o, mw.a);
          chk("wr_data", regu_rd_data_o, mw.d);
        end
      end
    end
  task automatic step(input bit ex_en, input logic [4:0] ex_a, input logic [31:0] ex_d, input bit iss,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input bit rdu);
    bit rdy, stl, go;
    cyc_t c;
    wr_t w;
    @(posedge clk);
    #1;
    if (auto_lu && !lu_v && luq.size() > 0 && $urandom_range(0, 2) == 0) begin
      lu_v = 1;
      lu_rd = luq.pop_front();
      lu_d = $urandom;
    end
    if (ex_en && pend[ex_a]) ex_en = 0;
    rdy = lu_v && !ex_en;
    stl = eff(r1, rdy) || eff(r2, rdy) || ((rdu || iss) && eff(rd, rdy)) || denied >= SM;
    go = iss && !stl;
    ex_wr_en_i = ex_en; ex_rd_addr_i = ex_a; ex_rd_data_i = ex_d;
    lu_issue_i = go; lu_issue_rd_i = rd;
    lu_wb_valid_i = lu_v; lu_wb_rd_i = lu_rd; lu_wb_data_i = lu_d;
    id_rs1_addr_i = r1; id_rs2_addr_i = r2; id_rd_addr_i = rd; id_rd_used_i = rdu || iss;
    c.rdy = rdy;
    c.stl = stl;
    c.wen = ex_en ? ex_a != 0 : lu_v && lu_rd != 0;
    if (c.wen) begin
      w.a = ex_en ? ex_a : lu_rd;
      w.d = ex_en ? ex_d : lu_d;
      wq.push_back(w);
    end
    cycq.push_back(c);
    denied = (lu_v && !rdy) ? (denied < SM ? denied + 1 : SM) : 0;
    if (rdy) begin
      pend[lu_rd] = 0;
      lu_v = 0;
    end
    if (go) begin
      if (rd != 0) pend[rd] = 1;
      if (auto_lu) luq.push_back(rd);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, regu_rd_wr_en_o, 0);
    chk({tag, "_addr"}, regu_rd_addr_o, 0);
    chk({tag, "_data"}, regu_rd_data_o, 0);
    chk({tag, "_ready"}, lu_wb_ready_o, 0);
    chk({tag, "_stall"}, id_stall_o, 0);
  endtask
  initial begin
    pend = '{default: 0};
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1;
    step(0, 0, 0, 1, 0, 0, 7, 0);
    lu_v = 1; lu_rd = 7; lu_d = 32'h22;
    step(1, 3, 32'h11, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 9, 0);
    repeat (3) step(0, 0, 0, 0, 0, 9, 0, 0);
    lu_v = 1; lu_rd = 9; lu_d = 32'h99;
    step(0, 0, 0, 0, 0, 9, 0, 0);
    step(0, 0, 0, 0, 0, 9, 0, 0);
    step(0, 0, 0, 1, 0, 0, 9, 0);
    lu_v = 1; lu_rd = 9; lu_d = 32'h9a;
    step(0, 0, 0, 1, 0, 0, 9, 0);
    step(0, 0, 0, 0, 9, 0, 0, 0);
    lu_v = 1; lu_rd = 9; lu_d = 32'h9b;
    step(0, 0, 0, 0, 9, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    lu_v = 1; lu_rd = 0; lu_d = 32'h55;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 12, 0);
    lu_v = 1; lu_rd = 12; lu_d = 32'hc0;
    for (int i = 0; i < 6; i++) step(1, 5'(i + 1), $urandom, 0, 3, 4, 0, 0);
    step(0, 0, 0, 0, 3, 4, 0, 0);
    step(0, 0, 0, 0, 3, 4, 0, 0);
    step(0, 0, 0, 1, 0, 0, 5, 0);
    lu_v = 1; lu_rd = 5; lu_d = 32'h5;
    step(1, 2, 32'h77, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk_zero("mid_reset");
    pend = '{default: 0}; denied = 0; luq.delete(); lu_v = 0; cycq.delete(); wq.delete();
    ex_wr_en_i = 0; lu_issue_i = 0; lu_wb_valid_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    step(0, 0, 0, 0, 5, 0, 0, 0);
    auto_lu = 1;
    repeat (1500)
      step($urandom_range(0, 1) == 1, 5'($urandom), $urandom, $urandom_range(0, 2) == 0,
           5'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 1) == 1);
    repeat (150) step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain_cycles", cycq.size(), 0);
    chk("drain_writes", wq.size(), 0);
    chk("drain_lu", luq.size() + lu_v, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
